// File: rtl/bitrev_reorder_pkg.sv
// bitrev_reorder_pkg: shared helpers for the bit-reversal reorder buffer
package bitrev_reorder_pkg;

    function automatic int frame_len(input int a);
        return 1 << a;
    endfunction

endpackage

// File: rtl/bitrev_reorder_reverse.sv
// reverse: combinational bit-order reversal; in - W-bit value, out - same bits in reversed order
module reverse #(
    parameter int W = 4
) (
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign out[i] = in[W-1-i];
    end

endmodule

// File: rtl/bitrev_reorder.sv
// bitrev_reorder: ping-pong frame buffer emitting each N=2**A word frame in bit-reversed index order
// clock - rising edge; reset - async active-high; flush - sync drop of all buffered data
// in_valid/in_ready/in_data - natural-order input stream
// out_valid/out_ready/out_data/out_last - reordered output stream, out_last on word N-1
module bitrev_reorder
    import bitrev_reorder_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    localparam int N = frame_len(A);

    logic [W-1:0] mem [2][N];
    logic         wbank, rbank;
    logic [A-1:0] wcnt, rcnt, raddr;
    logic [1:0]   full;
    logic         in_fire, out_fire;

    // a bank being drained is full, so it can never also be the write target
    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign out_data  = mem[rbank][raddr];
    assign out_last  = out_valid && &rcnt;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    reverse #(.W(A)) rev (.in(rcnt), .out(raddr));

    always_ff @(posedge clock)
        if (in_fire) mem[wbank][wcnt] <= in_data;

    // fill and drain completion always hit different banks, so both flag updates coexist
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
            full  <= '0;
        end else if (flush) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
            full  <= '0;
        end else begin
            if (in_fire) begin
                wcnt <= wcnt + 1'b1;
                if (&wcnt) begin
                    full[wbank] <= 1'b1;
                    wbank       <= !wbank;
                end
            end
            if (out_fire) begin
                rcnt <= rcnt + 1'b1;
                if (&rcnt) begin
                    full[rbank] <= 1'b0;
                    rbank       <= !rbank;
                end
            end
        end

endmodule
